debug_spi_transmitter: RTL and testbench
========================================

# debug_spi_transmitter

Simulation-grade SPI master used by benches to drive a bridge's SPI slave port one 16-bit word at a time. It accepts words over a push handshake, shifts each word out MSB-first on MOSI and captures MISO at the same time. Each received word is presented on a second push-style output. It sits between a bench push helper and the DUT's SPI interface; it has no protocol knowledge (addresses, escapes, checksums are the caller's concern).

## Interface
Parameters:
- SCK_HALF, default 2: clk cycles per SCK half-period (≥1); SCK period = 2·SCK_HALF clk.
- CS_GAP, default 4: minimum clk cycles nCS stays high between words (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nRst  in  1  reset, synchronous, active-low.
- push_data  in  16  word to transmit.
- push_request  in  1  word available; held high by caller until push_done.
- push_done  out  1  one-cycle pulse: word fully transferred.
- rcvd_data  out  16  word captured from MISO; held until next transfer completes.
- rcvd_request  out  1  one-cycle pulse: rcvd_data valid.
- spi_nCS  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idle low (CPOL=0).
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

## Operation
- SPI mode 0: MOSI valid before each SCK rising edge, MISO sampled on rising edge, MOSI advances after falling edge. MSB first, 16 bits per nCS assertion.
- States: IDLE → SHIFT → GAP → IDLE.
- IDLE: nCS=1, sck=0. If push_request=1, latch push_data into shift register, go to SHIFT.
- SHIFT: nCS=0, mosi=tx[15]. Half-period counter 0..SCK_HALF-1 toggles sck at wrap. On rising toggle: rx ← {rx[14:0], spi_miso}. On falling toggle: tx ← tx<<1, bit counter++. After 16th falling toggle: rcvd_data ← rx, pulse rcvd_request and push_done, nCS=1, go to GAP.
- GAP: nCS=1, sck=0, mosi=0 for CS_GAP cycles, then IDLE. push_request is ignored in SHIFT and GAP.
- The caller must drop push_request or present the next word within the cycle after push_done. A request still high in IDLE is treated as a new word.
- rcvd_data is not cleared between words.

## Timing
- Reset values: spi_nCS=1, spi_sck=0, spi_mosi=0, push_done=0, rcvd_request=0, rcvd_data=0, state IDLE, counters 0.
- Request sampled at edge t0. At t0+1: nCS=0, mosi=bit15, sck=0.
- Rising SCK edge k (k=0..15) occurs at t0+1+SCK_HALF·(2k+1). Falling edge k occurs at t0+1+SCK_HALF·(2k+2).
- Completion cycle t0+1+32·SCK_HALF: nCS=1, rcvd_request=push_done=1 for exactly one cycle, rcvd_data updated in the same cycle.
- Next word can be sampled no earlier than completion+CS_GAP. Minimum word period = 32·SCK_HALF+CS_GAP+1 clk.
- Reset asserted mid-transfer: next edge forces reset values. The partial word is discarded, with no rcvd_request or push_done pulse.
- SCK never glitches: high and low phases are each exactly SCK_HALF cycles.

## Test plan
- Loopback (miso=mosi), SCK_HALF=2: push 16'hAB00 → rcvd_request and push_done pulse together exactly 65 cycles after the request edge, rcvd_data=16'hAB00, nCS low for exactly 64 cycles.
- Slave model returns 16'h08B2 while master sends 16'h0AB2 → mosi bit sequence matches 0x0AB2 MSB-first at every rising SCK edge; rcvd_data=16'h08B2.
- Push 16'h8000 → mosi=1 only during bit 15 window, 0 otherwise; 16 rising SCK edges counted.
- Back-to-back push of 12 words (16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001, …) with request held continuously → exactly 12 done pulses. Between words nCS is high for ≥CS_GAP cycles and sck=0 while nCS=1; word order is preserved.
- Drop nRst for one cycle at bit 7 of a transfer → nCS=1, sck=0 next cycle, no done pulse. A following push of 16'h1234 completes normally with rcvd_data=16'h1234 under loopback.
- Toggle push_data while busy → transmitted word equals the value latched at t0.

Source files
------------

// File: rtl/debug_spi_transmitter.sv
// SPI mode-0 master for benches: shifts 16-bit words out MSB-first on MOSI
// while capturing MISO, one word per nCS assertion.
//
//   state    | meaning
//   ST_IDLE  | nCS high, sck low; waits for push_request and latches push_data
//   ST_SHIFT | nCS low; sck toggles every SCK_HALF clk; 16 bits in/out
//   ST_GAP   | nCS high, sck low, mosi low for CS_GAP clk before next word
module debug_spi_transmitter #(
  parameter int SCK_HALF = 2,
  parameter int CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [15:0] push_data,
  input  logic        push_request,
  output logic        push_done,
  output logic [15:0] rcvd_data,
  output logic        rcvd_request,
  output logic        spi_nCS,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HW-1:0] HALF_LOAD = HW'(SCK_HALF - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bit_cnt;
  logic [14:0]   tx;   // bits still to send; the current bit lives in spi_mosi
  logic [15:0]   rx;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state        <= ST_IDLE;
      half_cnt     <= '0;
      gap_cnt      <= '0;
      bit_cnt      <= '0;
      tx           <= '0;
      rx           <= '0;
      push_done    <= 1'b0;
      rcvd_request <= 1'b0;
      rcvd_data    <= '0;
      spi_nCS      <= 1'b1;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
    end else begin
      push_done    <= 1'b0;
      rcvd_request <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_nCS  <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          if (push_request) begin
            state    <= ST_SHIFT;
            spi_nCS  <= 1'b0;
            spi_mosi <= push_data[15];
            tx       <= push_data[14:0];
            half_cnt <= HALF_LOAD;
            bit_cnt  <= '0;
          end
        end

        ST_SHIFT: begin
          if (half_cnt == '0) begin
            half_cnt <= HALF_LOAD;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx      <= {rx[14:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                // last falling edge: rx already holds all 16 sampled bits
                rcvd_data    <= rx;
                rcvd_request <= 1'b1;
                push_done    <= 1'b1;
                spi_nCS      <= 1'b1;
                spi_mosi     <= 1'b0;
                gap_cnt      <= GAP_LOAD;
                state        <= ST_GAP;
              end else begin
                spi_mosi <= tx[14];
                tx       <= {tx[13:0], 1'b0};
              end
            end
          end else begin
            half_cnt <= half_cnt - HW'(1);
          end
        end

        ST_GAP: begin
          spi_nCS  <= 1'b1;
          spi_sck  <= 1'b0;
          spi_mosi <= 1'b0;
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_spi_transmitter.sv
// Bench for debug_spi_transmitter: directed pushes, a slave/loopback MISO
// model and a scoreboard of expected MOSI words and received words.
module tb_debug_spi_transmitter;
  localparam int SCK_HALF = 2;
  localparam int CS_GAP   = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [15:0] push_data = '0;
  logic        push_request = 1'b0;
  logic        push_done;
  logic [15:0] rcvd_data;
  logic        rcvd_request;
  logic        spi_nCS;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  debug_spi_transmitter #(.SCK_HALF(SCK_HALF), .CS_GAP(CS_GAP)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .push_data    (push_data),
    .push_request (push_request),
    .push_done    (push_done),
    .rcvd_data    (rcvd_data),
    .rcvd_request (rcvd_request),
    .spi_nCS      (spi_nCS),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        loopback = 1'b1;
  logic [15:0] slave_word = '0;
  logic [15:0] slv = '0;
  assign spi_miso = loopback ? spi_mosi : slv[15];

  logic [15:0] exp_tx_q[$];
  logic [15:0] exp_rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: slave model, SCK shape, scoreboard pops on rcvd_request.
  bit          mon_en = 1'b0;
  bit          seen_word = 1'b0;
  logic        prev_ncs = 1'b1;
  logic        prev_sck = 1'b0;
  logic [15:0] mosi_bits = '0;
  int          rise_cnt = 0;
  int          low_cnt = 0;
  int          run_len = 0;
  int          high_len = 0;
  int          done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!spi_nCS && prev_ncs) begin
          slv = slave_word;
          if (seen_word) chk("cs_gap", 32'(high_len >= CS_GAP), 1);
          rise_cnt  = 0;
          low_cnt   = 0;
          mosi_bits = '0;
        end else if (!spi_sck && prev_sck) begin
          slv = {slv[14:0], 1'b0};
        end

        if (!spi_nCS) begin
          low_cnt++;
          high_len = 0;
          if (spi_sck && !prev_sck) begin
            rise_cnt++;
            mosi_bits = {mosi_bits[14:0], spi_mosi};
          end
          if (prev_ncs) run_len = 1;
          else if (spi_sck == prev_sck) run_len++;
          else begin
            chk("sck_phase_len", run_len, SCK_HALF);
            run_len = 1;
          end
        end else begin
          high_len++;
          chk("sck_idle_when_cs_high", spi_sck, 0);
        end

        if (push_done != rcvd_request) chk("done_eq_rcvd_req", push_done, rcvd_request);
        if (rcvd_request) begin
          done_cnt++;
          seen_word = 1'b1;
          if (exp_tx_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("mosi_word", mosi_bits, exp_tx_q.pop_front());
            chk("rcvd_data", rcvd_data, exp_rx_q.pop_front());
            chk("sck_rise_count", rise_cnt, 16);
            chk("ncs_low_cycles", low_cnt, 32 * SCK_HALF);
          end
        end
        prev_ncs = spi_nCS;
        prev_sck = spi_sck;
      end
    end
  end

  task automatic send(input logic [15:0] w, input logic [15:0] rx_exp,
                      input bit hold, input bit toggle, output int lat);
    bit got;
    int t;
    exp_tx_q.push_back(w);
    exp_rx_q.push_back(rx_exp);
    push_data    = w;
    push_request = 1'b1;
    t   = cyc;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (toggle && i > 3) push_data = ~push_data;
      if (push_done) got = 1'b1;
    end
    lat = cyc - t;
    chk("done_timeout", got, 1);
    if (!hold) push_request = 1'b0;
  endtask

  logic [15:0] words [12] = '{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001,
                              16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0,
                              16'h1234, 16'h8001, 16'h7FFE, 16'hC33C};

  initial begin
    int lat;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", spi_nCS, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_done", push_done, 0);
    chk("rst_rcvd_req", rcvd_request, 0);
    chk("rst_rcvd_data", rcvd_data, 0);
    nRst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    send(16'hAB00, 16'hAB00, 1'b0, 1'b0, lat);
    chk("latency_first_word", lat, 1 + 32 * SCK_HALF);
    repeat (6) @(negedge clk);

    loopback = 1'b0;
    slave_word = 16'h08B2;
    send(16'h0AB2, 16'h08B2, 1'b0, 1'b0, lat);
    repeat (10) @(negedge clk);
    chk("rcvd_data_held", rcvd_data, 16'h08B2);
    loopback = 1'b1;

    send(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
    repeat (6) @(negedge clk);

    send(16'h3C5A, 16'h3C5A, 1'b0, 1'b1, lat);
    repeat (6) @(negedge clk);

    // abort in the bit-7 window, no scoreboard entry expected
    push_data    = 16'hC3C3;
    push_request = 1'b1;
    repeat (1 + 2 * SCK_HALF * 8) @(negedge clk);
    chk("abort_in_transfer", spi_nCS, 0);
    d0 = done_cnt;
    nRst = 1'b0;
    push_request = 1'b0;
    @(negedge clk);
    chk("abort_ncs", spi_nCS, 1);
    chk("abort_sck", spi_sck, 0);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_done", push_done, 0);
    nRst = 1'b1;
    repeat (80) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);

    send(16'h1234, 16'h1234, 1'b0, 1'b0, lat);
    chk("after_abort_data", rcvd_data, 16'h1234);
    repeat (6) @(negedge clk);

    d0 = done_cnt;
    for (int i = 0; i < 12; i++) send(words[i], words[i], (i < 11), 1'b0, lat);
    repeat (10) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 12);
    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("rx_queue_empty", exp_rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
